// File: rtl/fetch_ctrl_if.sv
// Handshake/bus bundle between the fetch controller and the pipeline.
// The slave modport is the controller; the master modport drives the requests.
interface fetch_ctrl_if;
    logic [31:0] pc_f;
    logic        hz_stall;
    logic        redirect_d;
    logic [31:0] target_d;
    logic        md_start_e;
    logic        md_is_div_e;
    logic        md_use_d;
    logic        pc_we;
    logic [31:0] npc;
    logic        stall_d;
    logic        flush_e;
    logic        md_busy;
    logic        halted;

    modport slave (
        input  pc_f, hz_stall, redirect_d, target_d, md_start_e, md_is_div_e, md_use_d,
        output pc_we, npc, stall_d, flush_e, md_busy, halted
    );

    modport master (
        output pc_f, hz_stall, redirect_d, target_d, md_start_e, md_is_div_e, md_use_d,
        input  pc_we, npc, stall_d, flush_e, md_busy, halted
    );
endinterface

// File: rtl/fetch_ctrl.sv
// Fetch controller: PC write/next-PC selection, hazard and mult/div interlock,
// pending redirect across stalls, and a permanent halt on an illegal next PC.
module fetch_ctrl (
    input  logic       clk,
    input  logic       reset,
    fetch_ctrl_if.slave bus
);
    typedef enum logic {RUN, HALT} state_e;

    localparam logic [31:0] PC_LO = 32'h0000_3000;
    localparam logic [31:0] PC_HI = 32'h0000_6FFC;

    state_e      state_q, state_d;
    logic [3:0]  md_cnt_q, md_cnt_d;
    logic        pend_vld_q, pend_vld_d;
    logic [31:0] pend_addr_q, pend_addr_d;
    logic        halted_q;

    logic        md_busy, stall, range_bad, pc_we, stall_d, flush_e;
    logic [31:0] npc;

    assign md_busy = (md_cnt_q != 4'd0);
    assign stall   = bus.hz_stall | (bus.md_use_d & (md_busy | bus.md_start_e));

    // A redirect in this cycle beats one held over from an earlier stall.
    always_comb begin
        npc = bus.pc_f + 32'd4;
        if (bus.redirect_d)
            npc = bus.target_d;
        else if (pend_vld_q)
            npc = pend_addr_q;
    end

    assign range_bad = (npc[1:0] != 2'b00) || (npc < PC_LO) || (npc > PC_HI);

    always_comb begin
        state_d = state_q;
        pc_we   = 1'b0;
        stall_d = 1'b1;
        flush_e = 1'b1;
        case (state_q)
            RUN: begin
                if (!stall) begin
                    stall_d = 1'b0;
                    flush_e = 1'b0;
                    if (range_bad)
                        state_d = HALT;
                    else
                        pc_we = 1'b1;
                end
            end
            HALT: begin
                state_d = HALT;
            end
        endcase
    end

    // The mult/div counter runs regardless of the controller state.
    always_comb begin
        md_cnt_d = md_cnt_q;
        if (bus.md_start_e)
            md_cnt_d = bus.md_is_div_e ? 4'd10 : 4'd5;
        else if (md_busy)
            md_cnt_d = md_cnt_q - 4'd1;
    end

    always_comb begin
        pend_vld_d  = pend_vld_q;
        pend_addr_d = pend_addr_q;
        if (pc_we) begin
            pend_vld_d = 1'b0;
        end else if (bus.redirect_d) begin
            pend_vld_d  = 1'b1;
            pend_addr_d = bus.target_d;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= RUN;
            md_cnt_q    <= 4'd0;
            pend_vld_q  <= 1'b0;
            pend_addr_q <= 32'd0;
            halted_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            md_cnt_q    <= md_cnt_d;
            pend_vld_q  <= pend_vld_d;
            pend_addr_q <= pend_addr_d;
            halted_q    <= (state_d == HALT);
        end
    end

    assign bus.pc_we   = pc_we;
    assign bus.npc     = npc;
    assign bus.stall_d = stall_d;
    assign bus.flush_e = flush_e;
    assign bus.md_busy = md_busy;
    assign bus.halted  = halted_q;
endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: directed scenarios plus random traffic, all outputs
// compared every cycle against a behavioural model of the fetch rules.
module tb_fetch_ctrl;
    logic clk = 1'b0;
    logic reset = 1'b0;
    int   n_chk = 0;
    int   n_err = 0;

    fetch_ctrl_if bus ();
    fetch_ctrl dut (.clk(clk), .reset(reset), .bus(bus.slave));

    always #5 clk = ~clk;

    // Model state: cycles of mult/div left, held redirect, halted flag.
    int          md_rem;
    bit          pv;
    logic [31:0] pa;
    bit          mh;
    bit          e_we, e_stl, e_bad;

    logic        obs_we, obs_sd, obs_fe, obs_busy, obs_halt;
    logic [31:0] obs_npc;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic set_in(input logic [31:0] pc, input bit hz, input bit rd,
                          input logic [31:0] tgt, input bit st, input bit dv, input bit use_);
        bus.pc_f        = pc;
        bus.hz_stall    = hz;
        bus.redirect_d  = rd;
        bus.target_d    = tgt;
        bus.md_start_e  = st;
        bus.md_is_div_e = dv;
        bus.md_use_d    = use_;
    endtask

    task automatic check_model();
        logic [31:0] enpc;
        bit busy;
        busy  = (md_rem > 0);
        e_stl = bus.hz_stall || (bus.md_use_d && (busy || bus.md_start_e));
        if (bus.redirect_d)  enpc = bus.target_d;
        else if (pv)         enpc = pa;
        else                 enpc = bus.pc_f + 32'd4;
        e_bad = (enpc % 4 != 0) || (enpc < 32'h3000) || (enpc > 32'h6FFC);
        e_we  = !mh && !e_stl && !e_bad;
        obs_we = bus.pc_we; obs_npc = bus.npc; obs_sd = bus.stall_d;
        obs_fe = bus.flush_e; obs_busy = bus.md_busy; obs_halt = bus.halted;
        chk("pc_we",   {31'd0, obs_we},   {31'd0, e_we});
        chk("npc",     obs_npc,           enpc);
        chk("stall_d", {31'd0, obs_sd},   {31'd0, (mh || e_stl)});
        chk("flush_e", {31'd0, obs_fe},   {31'd0, (mh || e_stl)});
        chk("md_busy", {31'd0, obs_busy}, {31'd0, busy});
        chk("halted",  {31'd0, obs_halt}, {31'd0, mh});
    endtask

    task automatic model_update();
        if (bus.md_start_e)  md_rem = bus.md_is_div_e ? 10 : 5;
        else if (md_rem > 0) md_rem = md_rem - 1;
        if (e_we) pv = 0;
        else if (bus.redirect_d) begin pv = 1; pa = bus.target_d; end
        if (!mh && !e_stl && e_bad) mh = 1;
    endtask

    task automatic cyc(input logic [31:0] pc, input bit hz, input bit rd,
                       input logic [31:0] tgt, input bit st, input bit dv, input bit use_);
        @(negedge clk);
        set_in(pc, hz, rd, tgt, st, dv, use_);
        #1;
        check_model();
        @(posedge clk);
        model_update();
    endtask

    // Reset is asserted between edges so its asynchronous effect is observed.
    task automatic do_reset(input bit use_);
        @(negedge clk);
        set_in(32'h3000, 0, 0, 32'h0, 0, 0, use_);
        reset = 1'b0;
        #1;
        md_rem = 0; pv = 0; pa = 32'h0; mh = 0;
        check_model();
        @(posedge clk);
        #2;
        reset = 1'b1;
    endtask

    initial begin
        md_rem = 0; pv = 0; pa = 32'h0; mh = 0;
        set_in(32'h3000, 0, 0, 32'h0, 0, 0, 0);

        do_reset(0);
        chk("rst_we",   {31'd0, obs_we},   32'd1);
        chk("rst_npc",  obs_npc,           32'h3004);
        chk("rst_busy", {31'd0, obs_busy}, 32'd0);
        chk("rst_sd",   {31'd0, obs_sd},   32'd0);
        chk("rst_fe",   {31'd0, obs_fe},   32'd0);

        cyc(32'h3000, 0, 0, 0, 0, 0, 0);
        chk("seq_we", {31'd0, obs_we}, 32'd1);
        chk("seq_npc", obs_npc, 32'h3004);
        chk("seq_sd", {31'd0, obs_sd}, 32'd0);

        cyc(32'h3000, 1, 1, 32'h3100, 0, 0, 0);
        chk("rds_t0_we", {31'd0, obs_we}, 32'd0);
        cyc(32'h3000, 0, 0, 32'h0, 0, 0, 0);
        chk("rds_t1_we", {31'd0, obs_we}, 32'd1);
        chk("rds_t1_npc", obs_npc, 32'h3100);
        cyc(32'h3100, 0, 0, 32'h0, 0, 0, 0);
        chk("rds_t2_npc", obs_npc, 32'h3104);

        cyc(32'h3104, 1, 1, 32'h3200, 0, 0, 0);
        cyc(32'h3104, 1, 1, 32'h3300, 0, 0, 0);
        cyc(32'h3104, 0, 0, 32'h0, 0, 0, 0);
        chk("ovr_npc", obs_npc, 32'h3300);

        cyc(32'h6FF8, 0, 0, 0, 0, 0, 0);
        chk("hi_edge_we", {31'd0, obs_we}, 32'd1);

        cyc(32'h3300, 0, 0, 0, 1, 1, 1);
        chk("div_t0_sd", {31'd0, obs_sd}, 32'd1);
        for (int i = 1; i <= 10; i++) begin
            cyc(32'h3300, 0, 0, 0, 0, 0, 1);
            chk("div_busy", {31'd0, obs_busy}, 32'd1);
            chk("div_sd", {31'd0, obs_sd}, 32'd1);
        end
        cyc(32'h3300, 0, 0, 0, 0, 0, 1);
        chk("div_end_we", {31'd0, obs_we}, 32'd1);
        chk("div_end_busy", {31'd0, obs_busy}, 32'd0);

        cyc(32'h3300, 0, 0, 0, 1, 1, 1);
        cyc(32'h3300, 0, 0, 0, 0, 0, 1);
        cyc(32'h3300, 0, 0, 0, 0, 0, 1);
        do_reset(1);
        chk("rst_div_busy", {31'd0, obs_busy}, 32'd0);
        cyc(32'h3000, 0, 0, 0, 0, 0, 1);
        chk("rst_div_we", {31'd0, obs_we}, 32'd1);

        cyc(32'h6FFC, 0, 0, 0, 0, 0, 0);
        chk("rng_npc", obs_npc, 32'h7000);
        chk("rng_we", {31'd0, obs_we}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            cyc(32'h3000, 0, (i == 1), 32'h3400, 0, 0, 0);
            chk("halt_flag", {31'd0, obs_halt}, 32'd1);
            chk("halt_we", {31'd0, obs_we}, 32'd0);
        end
        do_reset(0);

        cyc(32'h3000, 0, 1, 32'h3102, 0, 0, 0);
        chk("mis_we", {31'd0, obs_we}, 32'd0);
        cyc(32'h3000, 0, 0, 0, 0, 0, 0);
        chk("mis_halt", {31'd0, obs_halt}, 32'd1);
        do_reset(0);

        cyc(32'h3000, 0, 1, 32'h2FFC, 0, 0, 0);
        chk("lo_edge_we", {31'd0, obs_we}, 32'd0);
        do_reset(0);

        for (int n = 0; n < 3000; n++) begin
            logic [31:0] pc, tgt;
            bit hz, rd, st, dv, use_;
            pc   = 32'h3000 + 4 * $urandom_range(0, 4095);
            tgt  = ($urandom_range(0, 9) == 0) ? $urandom : 32'h3000 + 4 * $urandom_range(0, 4095);
            hz   = ($urandom_range(0, 4) == 0);
            rd   = ($urandom_range(0, 6) == 0);
            st   = ($urandom_range(0, 9) == 0);
            dv   = $urandom_range(0, 1) == 1;
            use_ = ($urandom_range(0, 2) == 0);
            if ((mh && $urandom_range(0, 3) == 0) || $urandom_range(0, 199) == 0)
                do_reset($urandom_range(0, 1) == 1);
            else
                cyc(pc, hz, rd, tgt, st, dv, use_);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
